lfsr_frame_ctrl: RTL and testbench

LFSR_FRAME_CTRL -- requirements
Module: lfsr_frame_ctrl

---
 rtl/lfsr_frame_ctrl.sv | 108 ++++++++++
 tb/tb_lfsr_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_frame_ctrl.sv
// Frame controller that feeds bytes bit-serially into an external CRC LFSR
// and captures the final checksum once the last byte has been shifted out.
module lfsr_frame_ctrl #(
  parameter int          LSB_FIRST = 1,
  parameter logic [31:0] FINAL_XOR = 32'hFFFF_FFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  input  logic        last_in,
  output logic        byte_ready_out,
  output logic        lfsr_rst_out,
  output logic        lfsr_valid_out,
  output logic        lfsr_bit_out,
  input  logic [31:0] lfsr_value_in,
  output logic [31:0] crc_out,
  output logic        crc_valid_out,
  output logic        busy_out,
  output logic [2:0]  state_dbg_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_WAIT   = 3'd2,
    S_SHIFT  = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic [7:0]  shreg_q;
  logic        last_q;
  logic [2:0]  bit_cnt_q;
  logic [31:0] crc_q;
  logic        handshake;

  // Byte handshake: a byte transfers on any edge where byte_valid_in and
  // byte_ready_out are both high; ready depends on the state register only.
  assign handshake = (state_q == S_WAIT) && byte_valid_in && !abort_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (abort_in) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_in) state_nxt = S_INIT;
        S_INIT:   state_nxt = S_WAIT;
        S_WAIT:   if (byte_valid_in) state_nxt = S_SHIFT;
        S_SHIFT:  if (bit_cnt_q == 3'd7) state_nxt = last_q ? S_SETTLE : S_WAIT;
        S_SETTLE: state_nxt = S_DONE;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // An abort during SETTLE must leave the previous checksum untouched.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg_q   <= 8'd0;
      last_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      crc_q     <= 32'd0;
    end else begin
      if (handshake) begin
        shreg_q   <= byte_in;
        last_q    <= last_in;
        bit_cnt_q <= 3'd0;
      end else if (state_q == S_SHIFT) begin
        shreg_q   <= (LSB_FIRST != 0) ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if ((state_q == S_SETTLE) && !abort_in) begin
        crc_q <= lfsr_value_in ^ FINAL_XOR;
      end
    end
  end

  always_comb begin
    byte_ready_out = (state_q == S_WAIT);
    lfsr_rst_out   = (state_q == S_INIT) || rst_in;
    lfsr_valid_out = (state_q == S_SHIFT);
    lfsr_bit_out   = 1'b0;
    if (state_q == S_SHIFT) begin
      lfsr_bit_out = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[7];
    end
    crc_valid_out  = (state_q == S_DONE);
    busy_out       = (state_q != S_IDLE);
  end

  assign crc_out       = crc_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_lfsr_frame_ctrl.sv
// Bench for lfsr_frame_ctrl: a bit-serial CRC-32 LFSR closes the loop, and a
// cycle-indexed timeline of expected outputs is built from frame latency rules.
module tb_lfsr_frame_ctrl;

  localparam int MAXC = 8192;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        byte_valid_in = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        last_in = 1'b0;
  logic        byte_ready_out;
  logic        lfsr_rst_out;
  logic        lfsr_valid_out;
  logic        lfsr_bit_out;
  logic [31:0] lfsr_value_in;
  logic [31:0] crc_out;
  logic        crc_valid_out;
  logic        busy_out;
  logic [2:0]  state_dbg_out;

  lfsr_frame_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .byte_valid_in (byte_valid_in),
    .byte_in       (byte_in),
    .last_in       (last_in),
    .byte_ready_out(byte_ready_out),
    .lfsr_rst_out  (lfsr_rst_out),
    .lfsr_valid_out(lfsr_valid_out),
    .lfsr_bit_out  (lfsr_bit_out),
    .lfsr_value_in (lfsr_value_in),
    .crc_out       (crc_out),
    .crc_valid_out (crc_valid_out),
    .busy_out      (busy_out),
    .state_dbg_out (state_dbg_out)
  );

  // Clock / cycle counter / serial CRC-32 register (reflected, poly EDB88320)
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [31:0] lfsr_reg;
  always @(posedge clk_in) begin
    if (lfsr_rst_out) lfsr_reg <= 32'hFFFF_FFFF;
    else if (lfsr_valid_out)
      lfsr_reg <= (lfsr_reg >> 1) ^ (((lfsr_reg[0] ^ lfsr_bit_out) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
  end
  assign lfsr_value_in = lfsr_reg;

  // Expected-output timeline indexed by cycle number
  bit          e_busy [MAXC];
  bit          e_rdy  [MAXC];
  bit          e_lv   [MAXC];
  bit          e_bit  [MAXC];
  bit          e_crcv [MAXC];
  bit          e_lrst [MAXC];
  logic [31:0] e_crc  [MAXC];

  logic [7:0]  fb [16];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          cmp_on = 1'b1;

  int          lv_cnt = 0;
  int          crcv_cnt = 0;
  int          lrst_cnt = 0;
  int          last_crcv_cyc = 0;
  int          hs_q[$];
  logic [7:0]  obs_byte = 8'd0;

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle_from(input int c, input logic [31:0] crc_keep);
    for (int k = c; k < MAXC; k++) begin
      e_busy[k] = 0; e_rdy[k] = 0; e_lv[k] = 0; e_bit[k] = 0;
      e_crcv[k] = 0; e_lrst[k] = 0; e_crc[k] = crc_keep;
    end
  endtask

  task automatic compare_loop();
    logic [5:0] act, exp;
    forever begin
      @(negedge clk_in);
      if (cmp_on && cyc >= 1 && cyc < MAXC) begin
        act = {busy_out, byte_ready_out, lfsr_valid_out, lfsr_bit_out, crc_valid_out, lfsr_rst_out};
        exp = {e_busy[cyc], e_rdy[cyc], e_lv[cyc], e_bit[cyc], e_crcv[cyc], e_lrst[cyc]};
        n_checks++;
        if (act === exp && crc_out === e_crc[cyc]) n_pass++;
        else $display("FAIL cycle_outputs cyc=%0d state=%0d got %b/%h expected %b/%h",
                      cyc, state_dbg_out, act, crc_out, exp, e_crc[cyc]);
        if (lfsr_valid_out) begin lv_cnt++; obs_byte = {lfsr_bit_out, obs_byte[7:1]}; end
        if (crc_valid_out) begin crcv_cnt++; last_crcv_cyc = cyc; end
        if (lfsr_rst_out) lrst_cnt++;
        if (byte_valid_in && byte_ready_out) hs_q.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_in = 1'b1;
      idle_from(cyc + 1, 32'd0);
      e_lrst[cyc] = 1;
      tick();
    end
    rst_in = 1'b0;
  endtask

  task automatic noise(input bit hold);
    byte_valid_in = hold ? 1'b1 : 1'($urandom_range(0, 1));
    byte_in       = 8'($urandom);
    last_in       = 1'($urandom_range(0, 1));
  endtask

  // start+abort together, abort alone, or nothing: none of these may start a frame
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      start_in = 1'($urandom_range(0, 1));
      abort_in = start_in ? 1'b1 : 1'($urandom_range(0, 1));
      noise(1'b0);
      tick();
    end
    start_in = 1'b0;
    abort_in = 1'b0;
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset; kill_phase k = k-th cycle after the byte handshake
  task automatic send_frame(input int n, input int max_gap, input bit hold,
                            input int kill_kind, input int kill_byte, input int kill_phase);
    int h, c, gap, last_k;
    logic [7:0] b;
    logic [31:0] keep;
    c = cyc;
    start_in = 1'b1; abort_in = 1'b0; noise(hold);
    e_busy[c + 1] = 1; e_lrst[c + 1] = 1;
    tick();
    start_in = 1'($urandom_range(0, 1)); noise(hold);
    tick();
    for (int i = 0; i < n; i++) begin
      gap = (hold && i > 0) ? 0 : $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        start_in = 1'($urandom_range(0, 1));
        byte_valid_in = 1'b0; byte_in = 8'($urandom);
        e_busy[cyc] = 1; e_rdy[cyc] = 1;
        tick();
      end
      h = cyc; b = fb[i];
      start_in = 1'($urandom_range(0, 1));
      byte_valid_in = 1'b1; byte_in = b; last_in = (i == n - 1);
      e_busy[h] = 1; e_rdy[h] = 1;
      for (int k = 1; k <= 8; k++) begin
        e_busy[h + k] = 1; e_lv[h + k] = 1; e_bit[h + k] = b[k - 1];
      end
      if (i == n - 1) begin
        e_busy[h + 9] = 1; e_busy[h + 10] = 1; e_crcv[h + 10] = 1;
        for (int k = h + 10; k < MAXC; k++) e_crc[k] = crc32_of(n);
      end
      tick();
      last_k = (i == n - 1) ? 10 : 8;
      for (int k = 1; k <= last_k; k++) begin
        start_in = 1'($urandom_range(0, 1)); noise(hold);
        if (kill_kind != 0 && i == kill_byte && k == kill_phase) begin
          c = cyc;
          if (kill_kind == 1) begin abort_in = 1'b1; keep = e_crc[c]; end
          else begin rst_in = 1'b1; keep = 32'd0; end
          idle_from(c + 1, keep);
          if (kill_kind == 2) e_lrst[c] = 1;
          tick();
          abort_in = 1'b0; rst_in = 1'b0; start_in = 1'b0; byte_valid_in = 1'b0;
          return;
        end
        tick();
      end
    end
    start_in = 1'b0; byte_valid_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s_lv, s_crcv, s_lrst, nb, kk, kb, kp;
    logic [31:0] saved;
    fork compare_loop(); join_none
    idle_from(0, 32'd0);

    do_reset(2);
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_crc", crc_out, 32'd0);
    chk("reset_ready", 32'(byte_ready_out), 32'd0);
    idle_noise(3);

    // single byte A5: bit order and handshake-to-DONE latency
    fb[0] = 8'hA5;
    send_frame(1, 0, 1'b0, 0, 0, 0);
    chk("a5_bit_sequence", 32'(obs_byte), 32'h0000_00A5);
    chk("a5_done_latency", 32'(last_crcv_cyc - hs_q[hs_q.size() - 1]), 32'd10);
    chk("a5_crc", crc_out, crc32_of(1));
    idle_noise(2);

    // three bytes with valid held high
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    s_lv = lv_cnt; s_crcv = crcv_cnt;
    send_frame(3, 0, 1'b1, 0, 0, 0);
    chk("hold_hs_gap1", 32'(hs_q[hs_q.size() - 2] - hs_q[hs_q.size() - 3]), 32'd9);
    chk("hold_hs_gap2", 32'(hs_q[hs_q.size() - 1] - hs_q[hs_q.size() - 2]), 32'd9);
    chk("hold_lv_cycles", 32'(lv_cnt - s_lv), 32'd24);
    chk("hold_crcv_pulses", 32'(crcv_cnt - s_crcv), 32'd1);

    // "123456789" twice back to back: standard CRC-32 check value
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    s_lrst = lrst_cnt;
    send_frame(9, 2, 1'b0, 0, 0, 0);
    chk("check_value_1", crc_out, 32'hCBF4_3926);
    chk("lrst_pulses_1", 32'(lrst_cnt - s_lrst), 32'd1);
    saved = crc_out;
    s_lrst = lrst_cnt;
    send_frame(9, 2, 1'b0, 0, 0, 0);
    chk("check_value_repeat", crc_out, saved);
    chk("lrst_pulses_2", 32'(lrst_cnt - s_lrst), 32'd1);

    fb[0] = 8'h61;
    send_frame(1, 1, 1'b0, 0, 0, 0);
    chk("crc_of_a", crc_out, 32'hE8B7_BE43);

    // abort in 4th SHIFT cycle of byte 2
    fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h30;
    saved = crc_out; s_crcv = crcv_cnt;
    send_frame(3, 1, 1'b0, 1, 1, 4);
    chk("abort_busy", 32'(busy_out), 32'd0);
    idle_noise(2);
    chk("abort_crc_kept", crc_out, saved);
    chk("abort_no_pulse", 32'(crcv_cnt - s_crcv), 32'd0);

    // start and abort together in IDLE
    start_in = 1'b1; abort_in = 1'b1; tick();
    start_in = 1'b0; abort_in = 1'b0;
    chk("start_abort_idle", 32'(busy_out), 32'd0);

    // reset during SETTLE
    fb[0] = 8'h77; fb[1] = 8'h88;
    s_crcv = crcv_cnt;
    send_frame(2, 1, 1'b0, 2, 1, 9);
    chk("settle_reset_crc", crc_out, 32'd0);
    chk("settle_reset_no_pulse", 32'(crcv_cnt - s_crcv), 32'd0);
    idle_noise(2);

    // randomized frames with occasional abort/reset
    for (int f = 0; f < 30 && cyc < MAXC - 200; f++) begin
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) fb[i] = 8'($urandom);
      kk = $urandom_range(0, 7);
      if (kk > 2) kk = 0;
      kb = $urandom_range(0, nb - 1);
      kp = $urandom_range(1, (kb == nb - 1) ? 10 : 8);
      send_frame(nb, 3, 1'($urandom_range(0, 1)), kk, kb, kp);
      if (kk == 0) chk("rand_frame_crc", crc_out, crc32_of(nb));
      idle_noise($urandom_range(0, 3));
    end

    tick();
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
